// File: rtl/multi_chan_event_agg_pkg.sv
// rtl/multi_chan_event_agg_pkg.sv - shared helpers for the multi-channel event aggregator
package multi_chan_event_agg_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Result clamps at (2**w)-1 so the caller's counter never wraps.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/multi_chan_event_agg_rr_arb.sv
// rtl/multi_chan_event_agg_rr_arb.sv - combinational round-robin arbiter, search starts after ptr
module rr_arb
    import multi_chan_event_agg_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx
);

    always_comb begin
        int j;
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            j = (int'(ptr) + i) % NUM_CH;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/multi_chan_event_agg.sv
// rtl/multi_chan_event_agg.sv - sticky per-channel event capture with round-robin reporting
module multi_chan_event_agg
    import multi_chan_event_agg_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 2,
    parameter int CNT_W    = 8,
    parameter int CH_IDX_W = idx_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        ch_event,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [CH_IDX_W-1:0]      evt_ch,
    output logic [DATA_W-1:0]        evt_data,
    output logic                     any_out,
    output logic [CNT_W-1:0]         drop_cnt
);

    typedef struct packed {
        logic [CH_IDX_W-1:0] ch;
        logic [DATA_W-1:0]   data;
    } out_stage_t;

    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   set_v, drop_v, grant_v;
    logic [DATA_W-1:0]   data_q [NUM_CH];
    logic [DATA_W-1:0]   data_d [NUM_CH];
    logic [CH_IDX_W-1:0] ptr_q, ptr_d;
    logic                out_valid_q, out_valid_d;
    out_stage_t          out_q, out_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                load, grant, grant_valid;
    logic [CH_IDX_W-1:0] grant_idx;

    rr_arb #(
        .NUM_CH(NUM_CH),
        .IDX_W (CH_IDX_W)
    ) u_rr_arb (
        .req        (pending_q),
        .ptr        (ptr_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    assign load  = !out_valid_q || evt_ready;
    assign grant = load && grant_valid && !clear;
    assign set_v = ch_event & ch_mask;

    // A new set on the granted channel re-arms it; only an ungranted busy channel drops.
    always_comb begin
        grant_v   = '0;
        drop_v    = '0;
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_v[i] = grant && (grant_idx == CH_IDX_W'(i));
            drop_v[i]  = set_v[i] && pending_q[i] && !grant_v[i];
            if (clear)
                pending_d[i] = 1'b0;
            else if (set_v[i])
                pending_d[i] = 1'b1;
            else if (grant_v[i])
                pending_d[i] = 1'b0;
            data_d[i] = (set_v[i] && !drop_v[i] && !clear) ? ch_data[i*DATA_W +: DATA_W] : data_q[i];
        end
    end

    always_comb begin
        logic [31:0] n_drop;
        n_drop = '0;
        for (int i = 0; i < NUM_CH; i++)
            n_drop = n_drop + 32'(drop_v[i]);
        drop_cnt_d = clear ? '0 : CNT_W'(sat_add(32'(drop_cnt_q), n_drop, CNT_W));
    end

    // Channel/data hold their last values when the stage empties.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant;
            if (grant) begin
                out_d.ch   = grant_idx;
                out_d.data = data_q[grant_idx];
                ptr_d      = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            ptr_q       <= CH_IDX_W'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_q       <= '0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < NUM_CH; i++)
                data_q[i] <= '0;
        end else begin
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int i = 0; i < NUM_CH; i++)
                data_q[i] <= data_d[i];
        end
    end

    assign evt_valid = out_valid_q;
    assign evt_ch    = out_q.ch;
    assign evt_data  = out_q.data;
    assign any_out   = (|pending_q) || out_valid_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_multi_chan_event_agg.sv
// tb/tb_multi_chan_event_agg.sv - vector table plus scoreboard bench for multi_chan_event_agg
module tb_multi_chan_event_agg;

    logic       clk = 1'b0;
    logic       reset, clear, evt_ready;
    logic [3:0] ch_event, ch_mask;
    logic [7:0] ch_data;
    logic       evt_valid, any_out;
    logic [1:0] evt_ch, evt_data, drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic [3:0] ev;
        logic [7:0] data;
        logic [2:0] n;
        logic [7:0] exp_ch;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vecs [5];

    int exp_drop [7] = '{0, 0, 1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    multi_chan_event_agg #(
        .NUM_CH(4),
        .DATA_W(2),
        .CNT_W (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .ch_event (ch_event),
        .ch_data  (ch_data),
        .ch_mask  (ch_mask),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_ch   (evt_ch),
        .evt_data (evt_data),
        .any_out  (any_out),
        .drop_cnt (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got ch=%0d data=%0d, expected no transfer", evt_ch, evt_data);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_ch", 32'(evt_ch), 32'(e.ch));
                check("sb_data", 32'(evt_data), 32'(e.data));
            end
        end
    end

    task automatic wait_drain(input string name, input int n);
        int n_valid;
        int done;
        n_valid = 0;
        done    = 0;
        for (int c = 0; c < 20; c++) begin
            if (evt_valid) n_valid++;
            if (sb_q.size() == 0 && !evt_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        check({name, "_done"}, done, 1);
        check({name, "_nvalid"}, n_valid, n);
        check({name, "_any"}, 32'(any_out), 0);
    endtask

    task automatic run_vec(input int idx, input string name);
        vec_t v;
        v = vecs[idx];
        ch_event = v.ev;
        ch_data  = v.data;
        for (int k = 0; k < int'(v.n); k++)
            sb_q.push_back({v.exp_ch[2*k +: 2], v.exp_d[2*k +: 2]});
        tick();
        ch_event = '0;
        wait_drain(name, int'(v.n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b1111, 8'hE4, 3'd4, 8'hE4, 8'hE4};
        vecs[1] = '{4'b1000, 8'h40, 3'd1, 8'h03, 8'h01};
        vecs[2] = '{4'b0010, 8'h08, 3'd1, 8'h01, 8'h02};
        vecs[3] = '{4'b0101, 8'h13, 3'd2, 8'h02, 8'h0D};
        vecs[4] = '{4'b1010, 8'h80, 3'd2, 8'h0D, 8'h08};

        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ch_event  = 4'($urandom);
            ch_data   = 8'($urandom);
            ch_mask   = 4'($urandom);
            evt_ready = 1'($urandom);
            clear     = 1'($urandom);
            tick();
            check("rst_valid", 32'(evt_valid), 0);
            check("rst_ch", 32'(evt_ch), 0);
            check("rst_data", 32'(evt_data), 0);
            check("rst_any", 32'(any_out), 0);
            check("rst_drop", 32'(drop_cnt), 0);
        end
        reset     = 1'b0;
        clear     = 1'b0;
        ch_event  = '0;
        ch_data   = '0;
        ch_mask   = 4'hF;
        evt_ready = 1'b1;

        for (int i = 0; i < 5; i++)
            run_vec(i, $sformatf("vec%0d", i));

        ch_event = 4'b0100;
        ch_data  = 8'h20;
        sb_q.push_back({2'd2, 2'd2});
        tick();
        ch_event = '0;
        check("lat_t1_valid", 32'(evt_valid), 0);
        check("lat_t1_any", 32'(any_out), 1);
        tick();
        check("lat_t2_valid", 32'(evt_valid), 1);
        check("lat_t2_ch", 32'(evt_ch), 2);
        check("lat_t2_data", 32'(evt_data), 2);
        check("lat_t2_any", 32'(any_out), 1);
        tick();
        check("lat_t3_valid", 32'(evt_valid), 0);
        check("lat_t3_any", 32'(any_out), 0);

        evt_ready = 1'b0;
        ch_event  = 4'b0010;
        ch_data   = 8'h04;
        tick();
        ch_event = '0;
        tick();
        tick();
        tick();
        ch_event = 4'b0010;
        ch_data  = 8'h0C;
        tick();
        ch_data = 8'h08;
        tick();
        ch_event = '0;
        check("stall_valid", 32'(evt_valid), 1);
        check("stall_ch", 32'(evt_ch), 1);
        check("stall_data", 32'(evt_data), 1);
        check("stall_drop", 32'(drop_cnt), 1);
        check("stall_any", 32'(any_out), 1);
        sb_q.push_back({2'd1, 2'd1});
        sb_q.push_back({2'd1, 2'd3});
        evt_ready = 1'b1;
        wait_drain("stall_release", 2);

        ch_mask = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            ch_event = 4'b0100;
            ch_data  = 8'h30;
            tick();
            check("mask_valid", 32'(evt_valid), 0);
            check("mask_any", 32'(any_out), 0);
        end
        ch_event = '0;
        tick();
        check("mask_idle_any", 32'(any_out), 0);
        ch_mask   = 4'hF;
        evt_ready = 1'b0;
        ch_event  = 4'b0001;
        ch_data   = 8'h02;
        tick();
        ch_event = '0;
        tick();
        ch_event = 4'b0100;
        ch_data  = 8'h10;
        tick();
        ch_mask = 4'b1011;
        ch_data = 8'h30;
        tick();
        ch_event = '0;
        check("mask_pend_ch", 32'(evt_ch), 0);
        check("mask_pend_drop", 32'(drop_cnt), 1);
        sb_q.push_back({2'd0, 2'd2});
        sb_q.push_back({2'd2, 2'd1});
        evt_ready = 1'b1;
        wait_drain("mask_pend", 2);
        ch_mask = 4'hF;

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_drop", 32'(drop_cnt), 0);
        evt_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            ch_event = 4'b0001;
            ch_data  = (k == 0) ? 8'h01 : (k == 1) ? 8'h02 : 8'h03;
            tick();
            check($sformatf("sat_drop%0d", k), 32'(drop_cnt), exp_drop[k]);
        end
        ch_event = 4'b0010;
        ch_data  = 8'h0C;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        ch_event = '0;
        check("clr2_drop", 32'(drop_cnt), 0);
        check("clr2_valid", 32'(evt_valid), 1);
        check("clr2_ch", 32'(evt_ch), 0);
        check("clr2_data", 32'(evt_data), 1);
        sb_q.push_back({2'd0, 2'd1});
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("clr2_empty_valid", 32'(evt_valid), 0);
        check("clr2_empty_any", 32'(any_out), 0);

        ch_event = 4'b1000;
        ch_data  = 8'h80;
        tick();
        ch_event = '0;
        tick();
        check("mid_valid", 32'(evt_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(evt_valid), 0);
        check("mid_rst_ch", 32'(evt_ch), 0);
        check("mid_rst_data", 32'(evt_data), 0);
        check("mid_rst_any", 32'(any_out), 0);
        check("mid_rst_drop", 32'(drop_cnt), 0);

        evt_ready = 1'b1;
        run_vec(0, "post_rst");

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
